// File: rtl/hex_scan_driver.sv
// hex_scan_driver
//   Time-multiplexed driver for an 8-digit, active-low seven-segment display.
//   A prescaler produces one tick every SCAN_DIV cycles, and each tick moves
//   the scan to the next digit slot. The inputs are captured once per frame,
//   on the tick that starts digit 0, so a frame is never torn. Leading zeros
//   can be suppressed, and every digit can be forced dark on its own.
//
// Ports
//   clk100_i       system clock, rising edge
//   rst_i          asynchronous active-high reset
//   data_i         32-bit value; nibble k drives digit k (digit 0 rightmost)
//   digit_en_i     per-digit enable (0 = dark)
//   blank_zeros_i  1 = suppress leading-zero digits
//   hex_led_o      segments {g,f,e,d,c,b,a}, active-low, registered
//   hex_sel_o      digit selects, active-low, at most one low, registered
//   frame_o        one-cycle pulse while digit 0 of a new frame is first shown
module hex_scan_driver #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk100_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  digit_en_i,
  input  logic        blank_zeros_i,
  output logic [6:0]  hex_led_o,
  output logic [7:0]  hex_sel_o,
  output logic        frame_o
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_q;
  logic [7:0]    en_sh_q;
  logic          bz_sh_q;
  logic [6:0]    led_q, led_d;
  logic [7:0]    sel_q, sel_d;
  logic          frame_q;

  logic          tick;
  logic          frame_start;
  logic [31:0]   data_cur;
  logic [7:0]    en_cur;
  logic          bz_cur;
  logic [2:0]    top;
  logic [3:0]    nib;
  logic          lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick        = (div_cnt_q == DIV_MAX);
  assign frame_start = tick && (idx_q == 3'd7);
  assign div_cnt_d   = tick ? '0 : div_cnt_q + DW'(1);
  assign idx_d       = idx_q + 3'd1;

  // Digit 0 is decoded in the same tick that captures the frame, so the
  // freshly sampled inputs bypass the shadow registers for that slot.
  assign data_cur = frame_start ? data_i        : shadow_q;
  assign en_cur   = frame_start ? digit_en_i    : en_sh_q;
  assign bz_cur   = frame_start ? blank_zeros_i : bz_sh_q;

  // Highest nonzero nibble; the ascending scan leaves the top-most one.
  always_comb begin
    top = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (data_cur[4*k +: 4] != 4'h0) begin
        top = 3'(k);
      end
    end
  end

  assign nib = data_cur[{idx_d, 2'b00} +: 4];
  assign lit = en_cur[idx_d] && (!bz_cur || (idx_d <= top));

  always_comb begin
    sel_d = '1;
    led_d = '1;
    if (lit) begin
      sel_d = ~(8'd1 << idx_d);
      led_d = seg_decode(nib);
    end
  end

  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      idx_q     <= 3'd7;
      shadow_q  <= '0;
      en_sh_q   <= '0;
      bz_sh_q   <= 1'b0;
      led_q     <= '1;
      sel_q     <= '1;
      frame_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      frame_q   <= frame_start;
      if (frame_start) begin
        shadow_q <= data_i;
        en_sh_q  <= digit_en_i;
        bz_sh_q  <= blank_zeros_i;
      end
      if (tick) begin
        idx_q <= idx_d;
        led_q <= led_d;
        sel_q <= sel_d;
      end
    end
  end

  assign hex_led_o = led_q;
  assign hex_sel_o = sel_q;
  assign frame_o   = frame_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
module tb_hex_scan_driver;

  localparam int unsigned SD = 4;

  localparam logic [6:0] L0 = 7'b1000000;
  localparam logic [6:0] L1 = 7'b1111001;
  localparam logic [6:0] L2 = 7'b0100100;
  localparam logic [6:0] L3 = 7'b0110000;
  localparam logic [6:0] L4 = 7'b0011001;
  localparam logic [6:0] L5 = 7'b0010010;
  localparam logic [6:0] L6 = 7'b0000010;
  localparam logic [6:0] L7 = 7'b1111000;
  localparam logic [6:0] L8 = 7'b0000000;
  localparam logic [6:0] LA = 7'b0001000;
  localparam logic [6:0] LF = 7'b0001110;
  localparam logic [6:0] DK = 7'h7F;

  localparam logic [55:0] COUNT = {L7, L6, L5, L4, L3, L2, L1, L0};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  en;
  logic        bz;
  logic [6:0]  led;
  logic [7:0]  sel;
  logic        frm;

  always #5 clk = ~clk;

  hex_scan_driver #(.SCAN_DIV(SD)) dut (
    .clk100_i      (clk),
    .rst_i         (rst),
    .data_i        (data),
    .digit_en_i    (en),
    .blank_zeros_i (bz),
    .hex_led_o     (led),
    .hex_sel_o     (sel),
    .frame_o       (frm)
  );

  typedef struct packed {
    logic       frame;
    logic [7:0] sel;
    logic [6:0] led;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_on = 1'b0;
  exp_t mon_e, mon_a;

  // Monitor: one expected entry per clock cycle while enabled.
  always @(negedge clk) begin
    if (mon_on) begin
      mon_a = '{frame: frm, sel: sel, led: led};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL underflow: got frame=%0b sel=%h led=%b, no expectation queued",
                 mon_a.frame, mon_a.sel, mon_a.led);
      end else begin
        mon_e = q.pop_front();
        if (mon_a !== mon_e) begin
          bad++;
          $display("FAIL slot @%0t: got frame=%0b sel=%h led=%b, want frame=%0b sel=%h led=%b",
                   $time, mon_a.frame, mon_a.sel, mon_a.led,
                   mon_e.frame, mon_e.sel, mon_e.led);
        end
      end
    end
  end

  task automatic push_dark(input int n);
    for (int i = 0; i < n; i++) q.push_back('{frame: 1'b0, sel: 8'hFF, led: DK});
  endtask

  task automatic push_frame(input logic [55:0] leds, input logic [7:0] mask);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < int'(SD); c++) begin
        e.frame = (k == 0) && (c == 0);
        e.sel   = mask[k] ? ~(8'd1 << k) : 8'hFF;
        e.led   = mask[k] ? leds[7*k +: 7] : DK;
        q.push_back(e);
      end
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    data = 32'h76543210;
    en   = 8'hFF;
    bz   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", {frm, sel, led}, {1'b0, 8'hFF, DK});

    // Reset and first frame, then a second identical frame to see the wrap.
    push_dark(4);
    push_frame(COUNT, 8'hFF);
    rst    = 1'b0;
    mon_on = 1'b1;
    edges(4);                                   // start of frame 1
    push_frame(COUNT, 8'hFF);
    edges(32);                                  // start of frame 2

    data = 32'h0000_00A5; bz = 1'b1;
    push_frame({DK, DK, DK, DK, DK, DK, LA, L5}, 8'h03);
    edges(32);                                  // start of frame 3

    data = 32'h0;
    push_frame({DK, DK, DK, DK, DK, DK, DK, L0}, 8'h01);
    edges(32);                                  // start of frame 4

    data = 32'h11111111; bz = 1'b0;
    push_frame({L1, L1, L1, L1, L1, L1, L1, L1}, 8'hFF);
    edges(32);                                  // start of frame 5
    edges(13);                                  // digit 3 of frame 5
    data = 32'h88888888;
    push_frame({L8, L8, L8, L8, L8, L8, L8, L8}, 8'hFF);
    edges(19);                                  // start of frame 6

    data = 32'hFFFFFFFF; en = 8'b1010_0101;
    push_frame({LF, DK, LF, DK, DK, LF, DK, LF}, 8'hA5);
    edges(32);                                  // start of frame 7

    data = 32'h76543210; en = 8'hFF;
    push_frame(COUNT, 8'hFF);
    edges(32);                                  // start of frame 8
    edges(17);                                  // digit 4 of frame 8

    mon_on = 1'b0;
    q.delete();
    check_now("digit4_before_reset", {frm, sel, led}, {1'b0, 8'hEF, L4});
    #1 rst = 1'b1;
    #1;
    check_now("async_reset_dark", {frm, sel, led}, {1'b0, 8'hFF, DK});
    rst = 1'b0;
    push_dark(4);
    push_frame(COUNT, 8'hFF);
    mon_on = 1'b1;

    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    mon_on = 1'b0;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_scan_driver.md
# hex_scan_driver

Time-multiplexed driver for the 8-digit seven-segment display on the lab board. Sits directly downstream of the lab counter/`main` datapath: takes the 32-bit value to show (eight hex nibbles) and scans it onto the shared active-low segment bus and digit-select lines. Provides leading-zero blanking, per-digit enables, and a frame-start pulse. Data is latched once per frame so a display frame is never torn.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot; at 100 MHz this gives 1 kHz per digit. Legal range is ≥ 1.
- `clk100_i`  in  1: system clock; all logic on the rising edge.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `data_i`  in  32: value to display; nibble k drives digit k, with digit 0 rightmost.
- `digit_en_i`  in  8: per-digit enable; 0 forces that digit dark.
- `blank_zeros_i`  in  1: 1 suppresses leading-zero digits.
- `hex_led_o`  out  7: segments `{g,f,e,d,c,b,a}`, active-low.
- `hex_sel_o`  out  8: digit selects, active-low, at most one bit low.
- `frame_o`  out  1: one-cycle pulse marking the start of each frame.

## Operation
- **Prescaler** `div_cnt`, width `$clog2(SCAN_DIV)` (minimum 1):
  - counts 0 … SCAN_DIV-1, then wraps to 0;
  - `tick` = (`div_cnt` == SCAN_DIV-1); with SCAN_DIV=1, `tick` is high every cycle.
- **Digit index** `idx[2:0]`:
  - reset value is 7;
  - each `tick` advances it as 7 → 0 → 1 … → 7, wrapping modulo 8.
- **Frame latch.** On the `tick` where `idx` goes 7 → 0:
  - `data_i` loads into `shadow[31:0]`;
  - `digit_en_i` loads into `en_sh[7:0]`;
  - `blank_zeros_i` loads into `bz_sh`.
  - Digit 0 of that frame is decoded from the newly sampled values, not the old shadow.
  - Input changes mid-frame have no effect until the next frame.
- **Blanking**, evaluated on the latched values:
  - `top` = index of the highest nonzero nibble of the shadow; `top` = 0 if the shadow is all zero.
  - Digit k is lit iff `en_sh[k]` && (!`bz_sh` || k ≤ `top`).
  - Digit 0 is never blanked by zero suppression, so a value of 0 shows a single "0".
- **Registered outputs**, updated only on `tick`, for the new `idx`:
  - Lit digit: `hex_sel_o` = ~(1 << `idx`); `hex_led_o` = decode(nibble `idx`).
  - Dark digit: `hex_sel_o` = 8'hFF; `hex_led_o` = 7'h7F.
- **Decode**, active-low `{g..a}`: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- **Frame pulse.** `frame_o` is registered and is 1 for exactly the cycle in which digit 0's outputs first appear.
- **Reset values**, applied on assertion regardless of clock:
  - `hex_led_o` = 7'h7F, `hex_sel_o` = 8'hFF, `frame_o` = 0;
  - `div_cnt` = 0, `idx` = 7;
  - `shadow` = 0, `en_sh` = 0, `bz_sh` = 0.
- **Reset asserted mid-scan:** outputs go dark immediately. After release the scan restarts from the first `tick` with digit 0 and a fresh latch.

## Timing
- Count rising edges after `rst_i` deasserts as edge 1, 2, … Ticks occur at edges n·SCAN_DIV, for n ≥ 1.
- Outputs are dark for cycles before edge SCAN_DIV.
- Edge SCAN_DIV:
  - latches the inputs;
  - drives digit 0;
  - `frame_o` is high for the following cycle.
- Each digit is held SCAN_DIV cycles. The frame period is 8·SCAN_DIV cycles.
- **Latency:** a `data_i` change is visible between 1 and 8·SCAN_DIV cycles later, at the next frame's digit 0.
- There are no combinational paths from any input to any output.
- `hex_sel_o` never has two bits low in the same cycle.

## Test plan
Run all scenarios with SCAN_DIV=4.
- **Reset and first frame.** Assert `rst_i`, release, hold `data_i`=32'h76543210, `digit_en_i`=FF, `blank_zeros_i`=0.
  - Required: outputs 7F/FF through edge 3.
  - At edge 4: `hex_sel_o`=FE, `hex_led_o`=1000000, `frame_o`=1 for one cycle.
  - At edge 8: `hex_sel_o`=FD, `hex_led_o`=1111001.
  - The sequence continues to digit 7 (`hex_sel_o`=7F, `hex_led_o`=1111000), then wraps to digit 0.
- **Leading-zero blanking.** `data_i`=32'h0000_00A5, `blank_zeros_i`=1.
  - Required: digit 0 shows 0010010 ("5") and digit 1 shows 0001000 ("A").
  - Digits 2–7 have `hex_sel_o`=FF and `hex_led_o`=7F. `frame_o` still pulses every 32 cycles.
- **All-zero value with blanking.** `data_i`=0, `blank_zeros_i`=1.
  - Required: only digit 0 lit, with `hex_led_o`=1000000; all other slots dark.
- **Mid-frame data change.** Change `data_i` from 32'h11111111 to 32'h88888888 while `idx`=3.
  - Required: digits 3–7 of the current frame still show 1111001.
  - The next frame shows 0000000 on all digits.
- **Digit enables.** `digit_en_i`=8'b1010_0101, `data_i`=32'hFFFFFFFF.
  - Required: only digits 0, 2, 5 and 7 lit, each with `hex_led_o`=0001110.
  - Slots for digits 1, 3, 4 and 6 show `hex_sel_o`=FF.
- **Asynchronous reset mid-scan.** Pulse `rst_i` high between clock edges while digit 4 is lit.
  - Required: `hex_sel_o`=FF and `hex_led_o`=7F immediately, before the next clock edge.
  - After release, digit 0 appears exactly 4 edges later, with `frame_o`=1.
